mult_seq: RTL



---
 rtl/mult_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier retiring BITS_PER_CYC multiplier bits per clock.
// Optional feature macro MULT_SEQ_ACC_EN adds an accumulate stage: prod = mcand*mlier + addend.
module mult_seq #(
  parameter int  BW_MCAND     = 8,
  parameter int  BW_MLIER     = 8,
  parameter int  BITS_PER_CYC = 1,
  localparam int BW_PROD      = BW_MCAND + BW_MLIER
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                start,
  input  logic                mcand_is_signed,
  input  logic                mlier_is_signed,
  input  logic [BW_MCAND-1:0] mcand,
  input  logic [BW_MLIER-1:0] mlier,
`ifdef MULT_SEQ_ACC_EN
  input  logic [BW_PROD-1:0]  addend,
`endif
  output logic [BW_PROD-1:0]  prod,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_o
);

  // Handshake: start is accepted only while IDLE (including the cycle done is high);
  // busy stays high until the edge that loads prod, and done pulses for one cycle after it.
  localparam int K  = BITS_PER_CYC;
  localparam int N  = BW_MLIER / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = BW_MCAND + K + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BW_MCAND-1:0]      mcand_q, mcand_d;
  logic                     mcand_sgn_q, mcand_sgn_d;
  logic                     mlier_sgn_q, mlier_sgn_d;
  logic signed [BW_MCAND:0] hi_q, hi_d;
  logic [BW_MLIER-1:0]      lo_q, lo_d;
  logic [BW_PROD-1:0]       prod_q, prod_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
`ifdef MULT_SEQ_ACC_EN
  logic [BW_PROD-1:0]       addend_q, addend_d;
`endif

  logic                     last_iter;
  logic signed [BW_MCAND:0] mcand_ext;
  logic signed [K:0]        digit;
  logic signed [HW-1:0]     term;
  logic signed [HW-1:0]     sum;
  logic signed [BW_MCAND:0] hi_nxt;
  logic [BW_MLIER-1:0]      lo_nxt;

  // lo_q doubles as the multiplier shift register and the low product bits.
  // In the last iteration a signed multiplier's top bit gets negative weight.
  assign last_iter = (cnt_q == CW'(N - 1));
  assign mcand_ext = {mcand_sgn_q & mcand_q[BW_MCAND-1], mcand_q};
  assign digit     = {last_iter & mlier_sgn_q & lo_q[K-1], lo_q[K-1:0]};
  assign term      = HW'(mcand_ext) * HW'(digit);
  assign sum       = HW'(hi_q) + term;
  assign hi_nxt    = sum[HW-1:K];
  assign lo_nxt    = BW_MLIER'({sum[K-1:0], lo_q} >> K);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mcand_sgn_d = mcand_sgn_q;
    mlier_sgn_d = mlier_sgn_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    prod_d      = prod_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef MULT_SEQ_ACC_EN
    addend_d    = addend_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d     = mcand;
          mcand_sgn_d = mcand_is_signed;
          mlier_sgn_d = mlier_is_signed;
          lo_d        = mlier;
          hi_d        = '0;
          cnt_d       = '0;
`ifdef MULT_SEQ_ACC_EN
          addend_d    = addend;
`endif
          busy_d      = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        hi_d  = hi_nxt;
        lo_d  = lo_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
`ifdef MULT_SEQ_ACC_EN
          state_d = S_ACC;
`else
          prod_d  = {hi_nxt[BW_MCAND-1:0], lo_nxt};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
      S_ACC: begin
`ifdef MULT_SEQ_ACC_EN
        prod_d  = {hi_q[BW_MCAND-1:0], lo_q} + addend_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      prod_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mcand_sgn_q <= 1'b0;
      mlier_sgn_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      prod_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MULT_SEQ_ACC_EN
      addend_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mcand_sgn_q <= mcand_sgn_d;
      mlier_sgn_q <= mlier_sgn_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      prod_q      <= prod_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MULT_SEQ_ACC_EN
      addend_q    <= addend_d;
`endif
    end
  end

  assign prod    = prod_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule
